// File: rtl/interrupt_context_stack_if.sv
// Controller-side handshake bundle for the interrupt context stack.
// Latency: none (wires only).
// Backpressure: none; o_busy tells the PC/decoder to hold while the stack sequences.
// Ports: i_* are driven by the controller/PC side, o_* by the context stack.
interface interrupt_context_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             i_interrupt_enable;
    logic [WIDTH-1:0] i_interrupt_address;
    logic             i_recovery_enable;
    logic [WIDTH-1:0] i_pc;
    logic [WIDTH-1:0] i_flag;
    logic             i_error_clear;
    logic             o_busy;
    logic             o_pc_load;
    logic [WIDTH-1:0] o_pc_load_address;
    logic             o_flag_restore;
    logic [WIDTH-1:0] o_flag;
    logic [LW-1:0]    o_nest_level;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_interrupt_enable, i_interrupt_address, i_recovery_enable,
               i_pc, i_flag, i_error_clear,
        input  o_busy, o_pc_load, o_pc_load_address, o_flag_restore,
               o_flag, o_nest_level, o_overflow, o_underflow
    );

    modport slave (
        input  i_interrupt_enable, i_interrupt_address, i_recovery_enable,
               i_pc, i_flag, i_error_clear,
        output o_busy, o_pc_load, o_pc_load_address, o_flag_restore,
               o_flag, o_nest_level, o_overflow, o_underflow
    );
endinterface

// File: rtl/interrupt_context_stack.sv
// Pushes {flag, pc} on interrupt entry and pops it on return, then strobes a PC (and flag) load.
// Latency: event sampled at edge k -> SAVE/RESTORE k+1 -> load strobe k+2 -> IDLE k+3.
// Backpressure: one-deep pending flag per event type; o_busy holds the PC/decoder while sequencing.
// Ports: clk, rst (async active-high), bus (slave modport: controller inputs, load/flag/status outputs).
module interrupt_context_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    interrupt_context_stack_if.slave   bus
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_VECTOR,
        S_RESTORE,
        S_RETURN
    } state_t;

    state_t             state, state_nxt;
    logic               int_q, rec_q;
    logic               pend_int, pend_rec;
    logic [WIDTH-1:0]   pend_vec;
    logic [SPW-1:0]     sp;
    logic [WIDTH-1:0]   ctx_pc, ctx_flag, ctx_vec;
    logic               overflow, underflow;
    logic [2*WIDTH-1:0] stack [DEPTH];

    logic               int_edge, rec_edge, int_req, rec_req;
    logic               take_int, take_rec, ovf_evt, unf_evt;
    logic               int_clr, rec_clr;
    logic [AW-1:0]      wr_idx, rd_idx;

    assign int_edge = bus.i_interrupt_enable & ~int_q;
    assign rec_edge = bus.i_recovery_enable & ~rec_q;
    assign int_req  = int_edge | pend_int;
    assign rec_req  = rec_edge | pend_rec;

    // Interrupt always wins in IDLE; a recovery waits for the next IDLE visit.
    assign int_clr  = (state == S_IDLE) && int_req;
    assign rec_clr  = (state == S_IDLE) && !int_req && rec_req;

    // sp is guarded to 0..DEPTH-1 in SAVE and 1..DEPTH in RESTORE, so truncation is safe.
    assign wr_idx   = AW'(sp);
    assign rd_idx   = AW'(sp - SPW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take_int  = 1'b0;
        take_rec  = 1'b0;
        ovf_evt   = 1'b0;
        unf_evt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (int_req) begin
                    if (sp < SPW'(DEPTH)) begin
                        take_int  = 1'b1;
                        state_nxt = S_SAVE;
                    end else begin
                        ovf_evt   = 1'b1;
                    end
                end else if (rec_req) begin
                    if (sp != '0) begin
                        take_rec  = 1'b1;
                        state_nxt = S_RESTORE;
                    end else begin
                        unf_evt   = 1'b1;
                    end
                end
            end
            S_SAVE:    state_nxt = S_VECTOR;
            S_VECTOR:  state_nxt = S_IDLE;
            S_RESTORE: state_nxt = S_RETURN;
            S_RETURN:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Previous samples reset high so a level held through reset is not an event.
            int_q     <= 1'b1;
            rec_q     <= 1'b1;
            pend_int  <= 1'b0;
            pend_rec  <= 1'b0;
            pend_vec  <= '0;
            sp        <= '0;
            ctx_pc    <= '0;
            ctx_flag  <= '0;
            ctx_vec   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            int_q <= bus.i_interrupt_enable;
            rec_q <= bus.i_recovery_enable;

            // A second edge while a request is already pending is dropped, vector included.
            if (int_clr) begin
                pend_int <= 1'b0;
            end else if (int_edge && !pend_int) begin
                pend_int <= 1'b1;
                pend_vec <= bus.i_interrupt_address;
            end

            if (rec_clr)       pend_rec <= 1'b0;
            else if (rec_edge) pend_rec <= 1'b1;

            // Vector is copied at acceptance so a new edge during SAVE cannot alter the load.
            if (take_int) begin
                ctx_pc   <= bus.i_pc;
                ctx_flag <= bus.i_flag;
                ctx_vec  <= pend_int ? pend_vec : bus.i_interrupt_address;
            end

            if (state == S_SAVE) sp <= sp + SPW'(1);

            if (state == S_RESTORE) begin
                sp                 <= sp - SPW'(1);
                {ctx_flag, ctx_pc} <= stack[rd_idx];
            end

            // Set has priority over clear.
            overflow  <= ovf_evt | (overflow  & ~bus.i_error_clear);
            underflow <= unf_evt | (underflow & ~bus.i_error_clear);
        end
    end

    // Storage array carries no reset; only sp qualifies its contents.
    always_ff @(posedge clk) begin
        if (state == S_SAVE) stack[wr_idx] <= {ctx_flag, ctx_pc};
    end

    // Outputs decode registered state only; reset forcing IDLE kills any in-flight strobe.
    assign bus.o_busy            = (state != S_IDLE);
    assign bus.o_pc_load         = (state == S_VECTOR) || (state == S_RETURN);
    assign bus.o_pc_load_address = (state == S_VECTOR) ? ctx_vec :
                                   (state == S_RETURN) ? ctx_pc  : '0;
    assign bus.o_flag_restore    = (state == S_RETURN);
    assign bus.o_flag            = (state == S_RETURN) ? ctx_flag : '0;
    assign bus.o_nest_level      = sp;
    assign bus.o_overflow        = overflow;
    assign bus.o_underflow       = underflow;
endmodule

// File: tb/tb_interrupt_context_stack.sv
// Directed bench for interrupt_context_stack: entry/return sequencing, LIFO order, full/empty, priority, reset.
// Latency: checks the load strobe two cycles after the sampled edge.
// Backpressure: n/a (bench drives levels, observes o_busy).
module tb_interrupt_context_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    interrupt_context_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    interrupt_context_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire_int(input logic [15:0] pc, input logic [15:0] flg,
                            input logic [15:0] vec, input int level);
        bus.i_pc                = pc;
        bus.i_flag              = flg;
        bus.i_interrupt_address = vec;
        bus.i_interrupt_enable  = 1'b1;
        tick();
        check("int_save_busy", 32'(bus.o_busy), 32'd1);
        check("int_save_noload", 32'(bus.o_pc_load), 32'd0);
        tick();
        check("int_vec_load", 32'(bus.o_pc_load), 32'd1);
        check("int_vec_addr", 32'(bus.o_pc_load_address), 32'(vec));
        check("int_vec_norestore", 32'(bus.o_flag_restore), 32'd0);
        check("int_vec_level", 32'(bus.o_nest_level), 32'(level));
        bus.i_interrupt_enable = 1'b0;
        tick();
        check("int_idle_load", 32'(bus.o_pc_load), 32'd0);
        check("int_idle_busy", 32'(bus.o_busy), 32'd0);
    endtask

    task automatic fire_rec(input logic [15:0] pc, input logic [15:0] flg, input int level);
        bus.i_recovery_enable = 1'b1;
        tick();
        check("rec_restore_busy", 32'(bus.o_busy), 32'd1);
        check("rec_restore_noload", 32'(bus.o_pc_load), 32'd0);
        tick();
        check("rec_ret_load", 32'(bus.o_pc_load), 32'd1);
        check("rec_ret_frestore", 32'(bus.o_flag_restore), 32'd1);
        check("rec_ret_addr", 32'(bus.o_pc_load_address), 32'(pc));
        check("rec_ret_flag", 32'(bus.o_flag), 32'(flg));
        check("rec_ret_level", 32'(bus.o_nest_level), 32'(level));
        bus.i_recovery_enable = 1'b0;
        tick();
        check("rec_idle_busy", 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst                     = 1'b1;
        bus.i_interrupt_enable  = 1'b0;
        bus.i_interrupt_address = '0;
        bus.i_recovery_enable   = 1'b0;
        bus.i_pc                = '0;
        bus.i_flag              = '0;
        bus.i_error_clear       = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_pc_load", 32'(bus.o_pc_load), 32'd0);
        check("rst_addr", 32'(bus.o_pc_load_address), 32'd0);
        check("rst_frestore", 32'(bus.o_flag_restore), 32'd0);
        check("rst_flag", 32'(bus.o_flag), 32'd0);
        check("rst_level", 32'(bus.o_nest_level), 32'd0);
        check("rst_ovf", 32'(bus.o_overflow), 32'd0);
        check("rst_unf", 32'(bus.o_underflow), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_busy", 32'(bus.o_busy), 32'd0);

        // Single interrupt, then a nested one, then two LIFO returns
        fire_int(16'h0120, 16'h0004, 16'hFDA9, 1);
        fire_int(16'h0500, 16'h0008, 16'h1234, 2);
        fire_rec(16'h0500, 16'h0008, 1);
        fire_rec(16'h0120, 16'h0004, 0);

        // Recovery on empty stack
        bus.i_recovery_enable = 1'b1;
        tick();
        check("unf_busy", 32'(bus.o_busy), 32'd0);
        check("unf_noload", 32'(bus.o_pc_load), 32'd0);
        check("unf_flag", 32'(bus.o_underflow), 32'd1);
        tick();
        check("unf_noload2", 32'(bus.o_pc_load), 32'd0);
        check("unf_busy2", 32'(bus.o_busy), 32'd0);
        bus.i_recovery_enable = 1'b0;
        bus.i_error_clear     = 1'b1;
        tick();
        bus.i_error_clear     = 1'b0;
        check("unf_cleared", 32'(bus.o_underflow), 32'd0);

        // Fill the stack, then one more
        for (int i = 0; i < DEPTH; i++)
            fire_int(16'h1000 + 16'(i * 16), 16'(i), 16'h8000 + 16'(i), i + 1);
        bus.i_pc                = 16'hDEAD;
        bus.i_interrupt_address = 16'hBEEF;
        bus.i_interrupt_enable  = 1'b1;
        tick();
        check("ovf_flag", 32'(bus.o_overflow), 32'd1);
        check("ovf_busy", 32'(bus.o_busy), 32'd0);
        check("ovf_level", 32'(bus.o_nest_level), 32'd8);
        tick();
        check("ovf_noload", 32'(bus.o_pc_load), 32'd0);
        bus.i_interrupt_enable = 1'b0;
        bus.i_error_clear      = 1'b1;
        tick();
        bus.i_error_clear      = 1'b0;
        check("ovf_cleared", 32'(bus.o_overflow), 32'd0);

        // Overflow and clear in the same cycle: set wins
        bus.i_interrupt_enable = 1'b1;
        bus.i_error_clear      = 1'b1;
        tick();
        bus.i_error_clear      = 1'b0;
        bus.i_interrupt_enable = 1'b0;
        check("ovf_set_wins", 32'(bus.o_overflow), 32'd1);
        check("ovf_level2", 32'(bus.o_nest_level), 32'd8);
        tick();

        // Drain in LIFO order
        for (int i = DEPTH - 1; i >= 0; i--)
            fire_rec(16'h1000 + 16'(i * 16), 16'(i), i);

        // Simultaneous interrupt and recovery edges at sp = 1
        fire_int(16'h0AAA, 16'h0011, 16'h2000, 1);
        bus.i_pc                = 16'h0BBB;
        bus.i_flag              = 16'h0022;
        bus.i_interrupt_address = 16'h3000;
        bus.i_interrupt_enable  = 1'b1;
        bus.i_recovery_enable   = 1'b1;
        tick();
        check("sim_save_busy", 32'(bus.o_busy), 32'd1);
        tick();
        check("sim_vec_load", 32'(bus.o_pc_load), 32'd1);
        check("sim_vec_addr", 32'(bus.o_pc_load_address), 32'h3000);
        check("sim_vec_norestore", 32'(bus.o_flag_restore), 32'd0);
        check("sim_vec_level", 32'(bus.o_nest_level), 32'd2);
        bus.i_interrupt_enable = 1'b0;
        bus.i_recovery_enable  = 1'b0;
        tick();
        check("sim_idle_busy", 32'(bus.o_busy), 32'd0);
        tick();
        check("sim_restore_busy", 32'(bus.o_busy), 32'd1);
        check("sim_restore_noload", 32'(bus.o_pc_load), 32'd0);
        tick();
        check("sim_ret_load", 32'(bus.o_pc_load), 32'd1);
        check("sim_ret_frestore", 32'(bus.o_flag_restore), 32'd1);
        check("sim_ret_addr", 32'(bus.o_pc_load_address), 32'h0BBB);
        check("sim_ret_flag", 32'(bus.o_flag), 32'h0022);
        check("sim_ret_level", 32'(bus.o_nest_level), 32'd1);
        tick();
        fire_rec(16'h0AAA, 16'h0011, 0);

        // Reset asserted during SAVE; level stays high across release
        fire_int(16'h0300, 16'h0001, 16'h4000, 1);
        bus.i_interrupt_address = 16'h5000;
        bus.i_interrupt_enable  = 1'b1;
        tick();
        check("mid_save_busy", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        check("mid_rst_load", 32'(bus.o_pc_load), 32'd0);
        check("mid_rst_level", 32'(bus.o_nest_level), 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post_rst_nobusy", 32'(bus.o_busy), 32'd0);
            check("post_rst_noload", 32'(bus.o_pc_load), 32'd0);
        end
        check("post_rst_level", 32'(bus.o_nest_level), 32'd0);
        bus.i_interrupt_enable = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
